// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation decoder and the iterative multiply/divide unit.
package alu_pkg;

    // ALU operation codes (low four bits of Operation)
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;  // also BNE
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_LUI  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_BGEU = 4'b1011;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1101;  // also BLTU
    localparam logic [3:0] OP_BGE  = 4'b1111;

    localparam logic [3:0] OP_BNE  = OP_XOR;
    localparam logic [3:0] OP_BLTU = OP_SLTU;

    // Funct7 patterns of interest
    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Main-decoder ALUOp field
    typedef enum logic [1:0] {
        AluOpMem    = 2'b00,
        AluOpBranch = 2'b01,
        AluOpReg    = 2'b10,
        AluOpJump   = 2'b11
    } aluop_e;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        MduIdle = 2'b00,
        MduCalc = 2'b01,
        MduDone = 2'b10
    } mdu_state_t;

endpackage

// File: rtl/alu_mdu_controller_if.sv
// EX-stage bundle between the pipeline and the ALU/MDU controller.
interface alu_mdu_controller_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OPW  = 4
);
    logic            valid_i;
    logic            is_imm;
    logic [1:0]      ALUOp;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic            flush_i;
    logic [OPW-1:0]  Operation;
    logic            use_mdu;
    logic            stall_o;
    logic [XLEN-1:0] mdu_result;
    logic            mdu_done;

    // Pipeline side
    modport master (
        output valid_i, is_imm, ALUOp, Funct7, Funct3, srcA, srcB, flush_i,
        input  Operation, use_mdu, stall_o, mdu_result, mdu_done
    );

    // Controller side
    modport slave (
        input  valid_i, is_imm, ALUOp, Funct7, Funct3, srcA, srcB, flush_i,
        output Operation, use_mdu, stall_o, mdu_result, mdu_done
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle with sign fix-up at the end.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            stall,
    output logic [XLEN-1:0] result,
    output logic            done
);
    localparam int unsigned CNTW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;     // partial product high half / partial remainder
    logic [XLEN-1:0] q_q, q_d;         // multiplier / dividend shifting into quotient
    logic [XLEN-1:0] b_q, b_d;         // multiplicand / divisor magnitude
    logic            neg_q, neg_d;     // final result must be negated
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            a_signed, b_signed, sign_a, sign_b;
    logic            is_div, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   acc_step, q_step, quo, rem, final_res;
    logic [2*XLEN-1:0] prod, prod_s;

    // Operand preparation and the special cases that bypass iteration
    always_comb begin
        a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
        b_signed = a_signed && (funct3 != 3'b010);
        sign_a   = a_signed && src_a[XLEN-1];
        sign_b   = b_signed && src_b[XLEN-1];
        a_mag    = sign_a ? -src_a : src_a;
        b_mag    = sign_b ? -src_b : src_b;
        is_div   = funct3[2];
        div_zero = is_div && (src_b == '0);
        div_ovf  = is_div && !funct3[0] && (src_a == MIN_NEG) && (src_b == '1);
        // funct3[1] separates REM* from DIV* within the divide group
        if (funct3[1]) begin
            fast_res = div_zero ? src_a : '0;
        end else begin
            fast_res = div_zero ? '1 : src_a;
        end
    end

    // One shift-add or restoring-subtract step, plus the sign-corrected result of that step
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
        div_shift = {acc_q, q_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (f3_q[2]) begin
            // Partial remainder stays below the divisor, so bit XLEN is a clean borrow flag
            if (!div_diff[XLEN]) begin
                acc_step = div_diff[XLEN-1:0];
                q_step   = {q_q[XLEN-2:0], 1'b1};
            end else begin
                acc_step = div_shift[XLEN-1:0];
                q_step   = {q_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step = mul_sum[XLEN:1];
            q_step   = {mul_sum[0], q_q[XLEN-1:1]};
        end
        prod   = {acc_step, q_step};
        prod_s = neg_q ? -prod : prod;
        quo    = neg_q ? -q_step : q_step;
        rem    = neg_q ? -acc_step : acc_step;
        if (f3_q[2]) begin
            final_res = f3_q[1] ? rem : quo;
        end else if (f3_q == 3'b000) begin
            final_res = prod_s[XLEN-1:0];
        end else begin
            final_res = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Sequencer next-state and outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        q_d      = q_q;
        b_d      = b_q;
        neg_d    = neg_q;
        f3_d     = f3_q;
        result_d = result_q;
        unique case (state_q)
            MduIdle: begin
                if (start && !flush) begin
                    if (div_zero || div_ovf) begin
                        result_d = fast_res;
                        state_d  = MduDone;
                    end else begin
                        acc_d   = '0;
                        q_d     = a_mag;
                        b_d     = b_mag;
                        // Remainder follows the dividend; everything else follows sign(a)^sign(b)
                        neg_d   = (funct3[2] && funct3[1]) ? sign_a : (sign_a ^ sign_b);
                        f3_d    = funct3;
                        cnt_d   = CNTW'(XLEN);
                        state_d = MduCalc;
                    end
                end
            end
            MduCalc: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = MduIdle;
                end else begin
                    acc_d = acc_step;
                    q_d   = q_step;
                    cnt_d = cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) begin
                        result_d = final_res;
                        state_d  = MduDone;
                    end
                end
            end
            MduDone: begin
                state_d = MduIdle;
            end
            default: begin
                state_d = MduIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MduIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            f3_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            f3_q     <= f3_d;
            result_q <= result_d;
        end
    end

    // rst_n gates stall so a held M-op cannot stall the pipe while reset is asserted
    always_comb begin
        stall  = rst_n && (((state_q == MduIdle) && start && !flush) || (state_q == MduCalc));
        done   = (state_q == MduDone) && !flush;
        result = result_q;
    end

endmodule

// File: rtl/alu_mdu_controller.sv
// EX-stage ALU operation decoder with an attached iterative multiply/divide unit.
module alu_mdu_controller
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OPW  = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    alu_mdu_controller_if.slave bus
);
    logic [3:0] op_code;
    logic       is_mdu;
    logic       mdu_stall;
    logic       mdu_done;
    logic [XLEN-1:0] mdu_result;

    // Decode ALUOp/Funct7/Funct3 into an ALU operation; M-extension ops park the ALU on ADD
    always_comb begin
        is_mdu  = bus.valid_i && (bus.ALUOp == AluOpReg) && !bus.is_imm &&
                  (bus.Funct7 == FUNCT7_MULDIV);
        op_code = OP_ADD;
        unique case (aluop_e'(bus.ALUOp))
            AluOpMem:  op_code = OP_ADD;
            AluOpJump: op_code = OP_LUI;
            AluOpBranch: begin
                unique case (bus.Funct3)
                    3'b000:  op_code = OP_BEQ;
                    3'b001:  op_code = OP_BNE;
                    3'b100:  op_code = OP_BLT;
                    3'b101:  op_code = OP_BGE;
                    3'b110:  op_code = OP_BLTU;
                    3'b111:  op_code = OP_BGEU;
                    default: op_code = OP_ADD;
                endcase
            end
            AluOpReg: begin
                if (is_mdu) begin
                    op_code = OP_ADD;
                end else begin
                    unique case (bus.Funct3)
                        // Immediate bits sit in Funct7 for ADDI, so only R-type may subtract
                        3'b000: op_code = (!bus.is_imm && bus.Funct7 == FUNCT7_ALT) ? OP_SUB
                                                                                    : OP_ADD;
                        3'b001: op_code = OP_SLL;
                        3'b010: op_code = OP_SLT;
                        3'b011: op_code = OP_SLTU;
                        3'b100: op_code = OP_XOR;
                        3'b101: op_code = (bus.Funct7 == FUNCT7_ALT) ? OP_SRA : OP_SRL;
                        3'b110: op_code = OP_OR;
                        3'b111: op_code = OP_AND;
                        default: op_code = OP_ADD;
                    endcase
                end
            end
            default: op_code = OP_ADD;
        endcase
    end

    mdu_iter #(
        .XLEN (XLEN)
    ) u_mdu_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (is_mdu),
        .flush  (bus.flush_i),
        .funct3 (bus.Funct3),
        .src_a  (bus.srcA),
        .src_b  (bus.srcB),
        .stall  (mdu_stall),
        .result (mdu_result),
        .done   (mdu_done)
    );

    // Drive the bundle outputs
    always_comb begin
        bus.Operation  = OPW'(op_code);
        bus.use_mdu    = is_mdu;
        bus.stall_o    = mdu_stall;
        bus.mdu_result = mdu_result;
        bus.mdu_done   = mdu_done;
    end

endmodule

// File: tb/tb_alu_mdu_controller.sv
// Self-checking bench for alu_mdu_controller: decode sweep, directed and random M-ops,
// flush abort and asynchronous reset mid-operation.
module tb_alu_mdu_controller;
    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mdu_controller_if #(.XLEN(XLEN), .OPW(OPW)) bus ();

    alu_mdu_controller #(
        .XLEN (XLEN),
        .OPW  (OPW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected ALU code, straight from the operation table
    function automatic logic [3:0] ref_op(input logic valid, input logic [1:0] aluop,
                                          input logic [6:0] f7, input logic [2:0] f3,
                                          input logic imm);
        logic [3:0] r;
        if (aluop == 2'b00) return 4'b0010;
        if (aluop == 2'b11) return 4'b0110;
        if (aluop == 2'b01) begin
            case (f3)
                3'd0: r = 4'b1000;
                3'd1: r = 4'b0100;
                3'd4: r = 4'b1100;
                3'd5: r = 4'b1111;
                3'd6: r = 4'b1101;
                3'd7: r = 4'b1011;
                default: r = 4'b0010;
            endcase
            return r;
        end
        if (valid && !imm && f7 == 7'h01) return 4'b0010;
        case (f3)
            3'd0: r = (!imm && f7 == 7'h20) ? 4'b0011 : 4'b0010;
            3'd1: r = 4'b1001;
            3'd2: r = 4'b0101;
            3'd3: r = 4'b1101;
            3'd4: r = 4'b0100;
            3'd5: r = (f7 == 7'h20) ? 4'b1010 : 4'b0111;
            3'd6: r = 4'b0001;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic bit ref_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (f3[2] && b == 32'd0) ||
               ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RV32M result computed with native 64-bit arithmetic
    function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        longint     sa = longint'($signed(a));
        longint     sb = longint'($signed(b));
        longint     ub = longint'({32'd0, b});
        logic [63:0] p;
        int          ia = a;
        int          ib = b;
        bit          ovf = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one decode vector with flush held so the MDU never starts
    task automatic dec_vec(input string tag, input logic valid, input logic [1:0] aluop,
                           input logic [6:0] f7, input logic [2:0] f3, input logic imm);
        bus.valid_i = valid;
        bus.ALUOp   = aluop;
        bus.Funct7  = f7;
        bus.Funct3  = f3;
        bus.is_imm  = imm;
        bus.flush_i = 1'b1;
        #1;
        check_eq({tag, " op"}, bus.Operation, ref_op(valid, aluop, f7, f3, imm));
        check_eq({tag, " use_mdu"}, bus.use_mdu,
                 valid && aluop == 2'b10 && !imm && f7 == 7'h01);
        check_eq({tag, " stall"}, bus.stall_o, 1'b0);
    endtask

    // Issue one M-op and hold it until mdu_done, checking latency, stall span and result
    task automatic run_mdu(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b);
        logic [31:0] exp_res = ref_mdu(f3, a, b);
        int          exp_lat = ref_fast(f3, a, b) ? 1 : XLEN + 1;
        int          lat = 0;
        int          stalls = 0;
        bit          seen = 0;
        bus.valid_i = 1'b1;
        bus.ALUOp   = 2'b10;
        bus.is_imm  = 1'b0;
        bus.Funct7  = 7'h01;
        bus.Funct3  = f3;
        bus.srcA    = a;
        bus.srcB    = b;
        bus.flush_i = 1'b0;
        #1;
        check_eq({tag, " use_mdu"}, bus.use_mdu, 1'b1);
        if (bus.stall_o) stalls++;
        for (int i = 0; i < XLEN + 8 && !seen; i++) begin
            tick();
            lat++;
            if (bus.mdu_done) seen = 1;
            else if (bus.stall_o) stalls++;
        end
        check_eq({tag, " latency"}, seen ? lat : -1, exp_lat);
        check_eq({tag, " stall cycles"}, stalls, exp_lat);
        check_eq({tag, " result"}, bus.mdu_result, exp_res);
        check_eq({tag, " stall in done"}, bus.stall_o, 1'b0);
        bus.valid_i = 1'b0;
        tick();
        check_eq({tag, " done pulse"}, bus.mdu_done, 1'b0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] held;
        bit          spurious;
        bus.valid_i = 1'b0;
        bus.ALUOp   = 2'b00;
        bus.Funct7  = 7'h00;
        bus.Funct3  = 3'd0;
        bus.is_imm  = 1'b0;
        bus.srcA    = '0;
        bus.srcB    = '0;
        bus.flush_i = 1'b0;

        #23;
        check_eq("reset stall", bus.stall_o, 1'b0);
        check_eq("reset done", bus.mdu_done, 1'b0);
        check_eq("reset result", bus.mdu_result, 32'd0);
        rst_n = 1'b1;
        tick();

        // Decode: directed points then random sweep
        dec_vec("ADDI alt f7", 1'b1, 2'b10, 7'h20, 3'd0, 1'b1);
        check_eq("ADDI code", bus.Operation, 4'b0010);
        dec_vec("SUB", 1'b1, 2'b10, 7'h20, 3'd0, 1'b0);
        check_eq("SUB code", bus.Operation, 4'b0011);
        dec_vec("SRAI", 1'b1, 2'b10, 7'h20, 3'd5, 1'b1);
        check_eq("SRAI code", bus.Operation, 4'b1010);
        dec_vec("BGEU", 1'b1, 2'b01, 7'h00, 3'd7, 1'b0);
        check_eq("BGEU code", bus.Operation, 4'b1011);
        dec_vec("BLTU", 1'b1, 2'b01, 7'h00, 3'd6, 1'b0);
        check_eq("BLTU code", bus.Operation, 4'b1101);
        dec_vec("LUI", 1'b1, 2'b11, 7'h00, 3'd0, 1'b0);
        check_eq("LUI code", bus.Operation, 4'b0110);
        dec_vec("MUL decode", 1'b1, 2'b10, 7'h01, 3'd0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            logic [6:0] f7;
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            dec_vec($sformatf("dec%0d", i), 1'($urandom), 2'($urandom), f7, 3'($urandom),
                    1'($urandom));
        end
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        tick();

        // Directed M-ops
        run_mdu("MUL -3*7", 3'd0, -32'sd3, 32'd7);
        check_eq("MUL -3*7 value", bus.mdu_result, 32'hFFFF_FFEB);
        run_mdu("MULH -3*7", 3'd1, -32'sd3, 32'd7);
        check_eq("MULH -3*7 value", bus.mdu_result, 32'hFFFF_FFFF);
        run_mdu("DIV -7/2", 3'd4, -32'sd7, 32'd2);
        check_eq("DIV -7/2 value", bus.mdu_result, 32'hFFFF_FFFD);
        run_mdu("REM -7/2", 3'd6, -32'sd7, 32'd2);
        check_eq("REM -7/2 value", bus.mdu_result, 32'hFFFF_FFFF);
        run_mdu("DIVU 100/7", 3'd5, 32'd100, 32'd7);
        check_eq("DIVU value", bus.mdu_result, 32'd14);
        run_mdu("REMU 100/7", 3'd7, 32'd100, 32'd7);
        check_eq("REMU value", bus.mdu_result, 32'd2);
        run_mdu("DIVU by 0", 3'd5, 32'd55, 32'd0);
        check_eq("DIVU by 0 value", bus.mdu_result, 32'hFFFF_FFFF);
        run_mdu("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("REM ovf value", bus.mdu_result, 32'd0);
        run_mdu("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mdu("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Random M-ops
        for (int i = 0; i < 16; i++) begin
            run_mdu($sformatf("rnd%0d", i), 3'($urandom), pick_operand(), pick_operand());
        end

        // Flush ten cycles into CALC
        run_mdu("MUL 5*5", 3'd0, 32'd5, 32'd5);
        held = bus.mdu_result;
        bus.valid_i = 1'b1;
        bus.ALUOp   = 2'b10;
        bus.Funct7  = 7'h01;
        bus.Funct3  = 3'd0;
        bus.srcA    = 32'd1234;
        bus.srcB    = 32'd99;
        for (int i = 0; i < 10; i++) tick();
        check_eq("flush pre stall", bus.stall_o, 1'b1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        #1;
        check_eq("flush stall", bus.stall_o, 1'b0);
        check_eq("flush done", bus.mdu_done, 1'b0);
        check_eq("flush result held", bus.mdu_result, held);
        spurious = 0;
        for (int i = 0; i < XLEN + 4; i++) begin
            tick();
            if (bus.mdu_done) spurious = 1;
        end
        check_eq("flush no late done", spurious, 1'b0);
        check_eq("flush result still held", bus.mdu_result, held);

        // Asynchronous reset mid-CALC
        bus.valid_i = 1'b1;
        bus.srcA    = 32'd77;
        bus.srcB    = 32'd3;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("areset stall", bus.stall_o, 1'b0);
        check_eq("areset done", bus.mdu_done, 1'b0);
        check_eq("areset result", bus.mdu_result, 32'd0);
        bus.valid_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_mdu("MUL 6*7", 3'd0, 32'd6, 32'd7);
        check_eq("MUL 6*7 value", bus.mdu_result, 32'd42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time limit so a stuck design still ends the run
    initial begin
        #500000;
        $display("FAIL timeout: got no completion, expected completion before 500000");
        $fatal(1);
    end

endmodule
